// File: rtl/axi_if.sv
// AXI-stream bundle: data, per-beat user sideband, valid/ready handshake and a tlast
// marker on the final beat of a packet.
interface axi_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned USER_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axi_capture_packetizer.sv
// Store-and-forward packetizer: buffers one capture burst, then emits a timestamp word,
// a length/flags/sequence word and the stored payload.
module axi_capture_packetizer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned USER_W = 8,
  parameter int unsigned TS_W   = 32,
  parameter int unsigned BUF_AW = 10
) (
  input  logic            clk,
  input  logic            rst,
  axi_if.slave            s_axi_if,
  axi_if.master           m_axi_if,
  input  logic [TS_W-1:0] latched_timestamp,
  output logic            busy,
  output logic [7:0]      seq_num,
  output logic [15:0]     trunc_count
);
  localparam int unsigned Depth = 2 ** BUF_AW;
  localparam int unsigned PtrW  = BUF_AW + 1;

  typedef enum logic [2:0] {StIdle, StFill, StDiscard, StHdr0, StHdr1, StPayload} state_e;

  state_e                   state_q, state_d;
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [TS_W-1:0]          ts_q, ts_d;
  logic                     trunc_flag_q, trunc_flag_d;
  logic [7:0]               seq_q, seq_d;
  logic [15:0]              trunc_cnt_q, trunc_cnt_d;
  logic                     s_tready_q, s_tready_d;
  logic                     m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
  logic [DATA_W-1:0]        m_tdata_q, m_tdata_d;
  logic [USER_W-1:0]        m_tuser_q, m_tuser_d;
  logic                     s_hs, m_hs, mem_we, go_hdr0;
  logic [BUF_AW-1:0]        rd_sel;
  logic [USER_W+DATA_W-1:0] rd_word;
  logic [USER_W+DATA_W-1:0] mem [Depth];

  assign s_hs    = s_axi_if.tvalid & s_tready_q;
  assign m_hs    = m_tvalid_q & m_axi_if.tready;
  assign rd_next = rd_ptr_q + PtrW'(1);
  // Prefetch: HDR1 loads entry 0, PAYLOAD loads the entry after the one on the bus.
  assign rd_sel  = (state_q == StPayload) ? rd_next[BUF_AW-1:0] : '0;
  assign rd_word = mem[rd_sel];

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[BUF_AW-1:0]] <= {s_axi_if.tuser, s_axi_if.tdata};
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ts_d         = ts_q;
    trunc_flag_d = trunc_flag_q;
    seq_d        = seq_q;
    trunc_cnt_d  = trunc_cnt_q;
    m_tvalid_d   = m_tvalid_q;
    m_tdata_d    = m_tdata_q;
    m_tuser_d    = m_tuser_q;
    m_tlast_d    = m_tlast_q;
    mem_we       = 1'b0;
    go_hdr0      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_hs) begin
          mem_we   = 1'b1;
          ts_d     = latched_timestamp;
          wr_ptr_d = PtrW'(1);
          if (s_axi_if.tlast) go_hdr0 = 1'b1;
          else                state_d = StFill;
        end
      end
      StFill: begin
        if (s_hs) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrW'(1);
          if (s_axi_if.tlast) begin
            go_hdr0 = 1'b1;
          end else if (wr_ptr_q == PtrW'(Depth - 1)) begin
            trunc_flag_d = 1'b1;
            if (trunc_cnt_q != 16'hFFFF) trunc_cnt_d = trunc_cnt_q + 16'd1;
            state_d = StDiscard;
          end
        end
      end
      StDiscard: begin
        if (s_hs && s_axi_if.tlast) go_hdr0 = 1'b1;
      end
      StHdr0: begin
        if (m_hs) begin
          state_d   = StHdr1;
          m_tdata_d = DATA_W'({seq_q, 7'd0, trunc_flag_q, 16'(wr_ptr_q)});
        end
      end
      StHdr1: begin
        if (m_hs) begin
          state_d                = StPayload;
          rd_ptr_d               = '0;
          {m_tuser_d, m_tdata_d} = rd_word;
          m_tlast_d              = (wr_ptr_q == PtrW'(1));
        end
      end
      StPayload: begin
        if (m_hs) begin
          if (m_tlast_q) begin
            state_d      = StIdle;
            m_tvalid_d   = 1'b0;
            m_tdata_d    = '0;
            m_tuser_d    = '0;
            m_tlast_d    = 1'b0;
            seq_d        = seq_q + 8'd1;
            trunc_flag_d = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
          end else begin
            rd_ptr_d               = rd_next;
            {m_tuser_d, m_tdata_d} = rd_word;
            m_tlast_d              = (rd_next == wr_ptr_q - PtrW'(1));
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (go_hdr0) begin
      state_d    = StHdr0;
      m_tvalid_d = 1'b1;
      m_tdata_d  = DATA_W'(ts_d);
      m_tuser_d  = '0;
      m_tlast_d  = 1'b0;
    end
    s_tready_d = (state_d == StIdle) || (state_d == StFill) || (state_d == StDiscard);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ts_q         <= '0;
      trunc_flag_q <= 1'b0;
      seq_q        <= '0;
      trunc_cnt_q  <= '0;
      s_tready_q   <= 1'b0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tuser_q    <= '0;
      m_tlast_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ts_q         <= ts_d;
      trunc_flag_q <= trunc_flag_d;
      seq_q        <= seq_d;
      trunc_cnt_q  <= trunc_cnt_d;
      s_tready_q   <= s_tready_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tuser_q    <= m_tuser_d;
      m_tlast_q    <= m_tlast_d;
    end
  end

  assign s_axi_if.tready = s_tready_q;
  assign m_axi_if.tvalid = m_tvalid_q;
  assign m_axi_if.tdata  = m_tdata_q;
  assign m_axi_if.tuser  = m_tuser_q;
  assign m_axi_if.tlast  = m_tlast_q;
  assign busy            = (state_q != StIdle);
  assign seq_num         = seq_q;
  assign trunc_count     = trunc_cnt_q;
endmodule
